fetch_pipeline_ctrl: RTL and testbench
======================================

// Module: fetch_pipeline_ctrl
// PURPOSE
//   Consumer of the hazard detection unit's stall/flush/bubble controls. Owns the PC
//   register, next-PC selection, the IF/ID pipeline register and the ID/EX control
//   register, applying pc_write/ifid_write/ifid_flush/control_mux each clock. Also keeps
//   stall/flush performance counters and a stall watchdog for verification/debug.
// PARAMETERS
//   RESET_PC   32'h0000_0000  PC value loaded on reset
//   CTRL_W     10             width of decoded control bundle passed ID->EX
//   CNT_W      16             width of stall/flush performance counters
//   MAX_STALL  8              consecutive stall cycles that trip stall_timeout (>=1)
// PORTS
//   clk            in   1       rising-edge clock
//   reset          in   1       asynchronous, active-high reset
//   pc_write       in   1       1 = PC may update; 0 = hold PC (stall)
//   ifid_write     in   1       1 = IF/ID may load; 0 = hold IF/ID
//   ifid_flush     in   1       1 = replace IF/ID contents with NOP
//   control_mux    in   1       1 = pass ctrl_id to ID/EX; 0 = insert bubble (all-zero)
//   branch_taken   in   1       redirect PC to branch_target
//   branch_target  in   32      branch destination; bits [1:0] ignored (forced 2'b00)
//   imem_instr     in   32      instruction read at imem_addr (combinational imem)
//   ctrl_id        in   CTRL_W  decoded controls of instruction in ID
//   imem_addr      out  32      current PC
//   ifid_instr     out  32      IF/ID instruction
//   ifid_pc4       out  32      IF/ID PC+4
//   ifid_valid     out  1       IF/ID holds a real (non-flushed) instruction
//   idex_ctrl      out  CTRL_W  ID/EX control bundle
//   stall_count    out  CNT_W   cycles with pc_write==0, saturating
//   flush_count    out  CNT_W   cycles with ifid_flush==1, saturating
//   stall_timeout  out  1       sticky: MAX_STALL consecutive stalls seen
// BEHAVIOUR
//   Reset (async, immediate): PC=RESET_PC; ifid_instr=0, ifid_pc4=0, ifid_valid=0;
//     idex_ctrl=0; stall_count=0; flush_count=0; internal stall_run=0; stall_timeout=0.
//     Reset mid-stall or mid-flush discards all state; first fetch after release is RESET_PC.
//   PC (per posedge): pc_write=0 -> hold (wins over branch_taken);
//     else branch_taken -> {branch_target[31:2],2'b00}; else PC+4, wraps mod 2^32.
//   IF/ID priority: ifid_flush -> instr=32'h0, pc4=0, valid=0 (overrides ifid_write=0);
//     else ifid_write -> instr=imem_instr, pc4=PC+4 (pre-update PC), valid=1; else hold.
//   ID/EX: idex_ctrl <= control_mux ? ctrl_id : '0 every cycle; no hold path.
//   Latency: instruction at PC appears on ifid_instr 1 cycle later; its controls on
//     idex_ctrl 1 further cycle later. Load-use stall = 1 bubble per stall cycle.
//   Counters: stall_count += 1 when pc_write==0; flush_count += 1 when ifid_flush==1;
//     both saturate at all-ones (no wrap). Both may increment in the same cycle.
//   Watchdog: stall_run increments while pc_write==0, clears to 0 when pc_write==1,
//     saturates at MAX_STALL; stall_timeout sets on the edge where stall_run reaches
//     MAX_STALL and stays 1 until reset.
//   All outputs registered except imem_addr (= PC register, also registered).
// TESTING
//   Reset: assert reset mid-run -> all outputs at reset values same cycle; PC=0 after.
//   Sequential fetch, all enables 1 -> imem_addr 0,4,8,C; ifid_pc4 lags by one: 4,8,C.
//   Load-use: pc_write=ifid_write=control_mux=0 for 1 cycle at PC=8 -> PC holds 8,
//     IF/ID holds, idex_ctrl=0 that cycle, stall_count=1.
//   Branch taken: pc_write=1, ifid_write=0, ifid_flush=1, target=32'h43 -> PC=32'h40,
//     ifid_instr=0, ifid_valid=0, flush_count=1.
//   Stall+branch_taken same cycle (pc_write=0) -> PC unchanged; flush still clears IF/ID.
//   Hold pc_write=0 for MAX_STALL=8 cycles -> stall_timeout rises after 8th edge, stays
//     1 after pc_write=1; stall_count with CNT_W=4 held 20 cycles -> saturates at 4'hF.

Source files
------------

// File: rtl/fetch_pipeline_ctrl.sv
// Fetch-side pipeline control: PC register, next-PC select, IF/ID and ID/EX registers
// driven by hazard-unit stall/flush/bubble controls, plus stall/flush counters and watchdog.
module fetch_pipeline_ctrl #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int unsigned CTRL_W    = 10,
   parameter int unsigned CNT_W     = 16,
   parameter int unsigned MAX_STALL = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              pc_write,
   input  logic              ifid_write,
   input  logic              ifid_flush,
   input  logic              control_mux,
   input  logic              branch_taken,
   input  logic [31:0]       branch_target,
   input  logic [31:0]       imem_instr,
   input  logic [CTRL_W-1:0] ctrl_id,
   output logic [31:0]       imem_addr,
   output logic [31:0]       ifid_instr,
   output logic [31:0]       ifid_pc4,
   output logic              ifid_valid,
   output logic [CTRL_W-1:0] idex_ctrl,
   output logic [CNT_W-1:0]  stall_count,
   output logic [CNT_W-1:0]  flush_count,
   output logic              stall_timeout
);

   localparam int unsigned    RunW   = $clog2(MAX_STALL + 1);
   localparam logic [RunW-1:0] MaxRun = RunW'(MAX_STALL);

   logic [31:0]       pc_q, pc_d, pc_plus4;
   logic [31:0]       ifid_instr_q, ifid_instr_d;
   logic [31:0]       ifid_pc4_q, ifid_pc4_d;
   logic              ifid_valid_q, ifid_valid_d;
   logic [CTRL_W-1:0] idex_ctrl_q, idex_ctrl_d;
   logic [CNT_W-1:0]  stall_count_q, stall_count_d;
   logic [CNT_W-1:0]  flush_count_q, flush_count_d;
   logic [RunW-1:0]   stall_run_q, stall_run_d;
   logic              stall_timeout_q, stall_timeout_d;

   // Targets are word aligned; the low bits are dropped on purpose.
   logic unused_target_bits;
   assign unused_target_bits = ^branch_target[1:0];

   assign pc_plus4 = pc_q + 32'd4;

   always_comb begin
      pc_d = pc_q;
      if (pc_write) begin
         pc_d = branch_taken ? {branch_target[31:2], 2'b00} : pc_plus4;
      end

      // Flush beats a held IF/ID so a squashed slot can never survive a stall.
      ifid_instr_d = ifid_instr_q;
      ifid_pc4_d   = ifid_pc4_q;
      ifid_valid_d = ifid_valid_q;
      if (ifid_flush) begin
         ifid_instr_d = 32'h0;
         ifid_pc4_d   = 32'h0;
         ifid_valid_d = 1'b0;
      end else if (ifid_write) begin
         ifid_instr_d = imem_instr;
         ifid_pc4_d   = pc_plus4;
         ifid_valid_d = 1'b1;
      end

      idex_ctrl_d = control_mux ? ctrl_id : '0;
   end

   always_comb begin
      stall_count_d = stall_count_q;
      if (!pc_write && (stall_count_q != '1)) begin
         stall_count_d = stall_count_q + CNT_W'(1);
      end

      flush_count_d = flush_count_q;
      if (ifid_flush && (flush_count_q != '1)) begin
         flush_count_d = flush_count_q + CNT_W'(1);
      end

      stall_run_d = stall_run_q;
      if (pc_write) begin
         stall_run_d = '0;
      end else if (stall_run_q < MaxRun) begin
         stall_run_d = stall_run_q + RunW'(1);
      end

      stall_timeout_d = stall_timeout_q | (stall_run_d == MaxRun);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_q            <= RESET_PC;
         ifid_instr_q    <= 32'h0;
         ifid_pc4_q      <= 32'h0;
         ifid_valid_q    <= 1'b0;
         idex_ctrl_q     <= '0;
         stall_count_q   <= '0;
         flush_count_q   <= '0;
         stall_run_q     <= '0;
         stall_timeout_q <= 1'b0;
      end else begin
         pc_q            <= pc_d;
         ifid_instr_q    <= ifid_instr_d;
         ifid_pc4_q      <= ifid_pc4_d;
         ifid_valid_q    <= ifid_valid_d;
         idex_ctrl_q     <= idex_ctrl_d;
         stall_count_q   <= stall_count_d;
         flush_count_q   <= flush_count_d;
         stall_run_q     <= stall_run_d;
         stall_timeout_q <= stall_timeout_d;
      end
   end

   assign imem_addr     = pc_q;
   assign ifid_instr    = ifid_instr_q;
   assign ifid_pc4      = ifid_pc4_q;
   assign ifid_valid    = ifid_valid_q;
   assign idex_ctrl     = idex_ctrl_q;
   assign stall_count   = stall_count_q;
   assign flush_count   = flush_count_q;
   assign stall_timeout = stall_timeout_q;

endmodule

// File: tb/tb_fetch_pipeline_ctrl.sv
// Directed bench for fetch_pipeline_ctrl: expectations are queued as stimulus is driven
// and popped against the DUT after each clock edge.
module tb_fetch_pipeline_ctrl;

   localparam int unsigned CTRL_W    = 10;
   localparam int unsigned CNT_W     = 4;
   localparam int unsigned MAX_STALL = 8;

   logic              clk = 1'b0;
   logic              reset;
   logic              pc_write, ifid_write, ifid_flush, control_mux, branch_taken;
   logic [31:0]       branch_target;
   logic [31:0]       imem_instr;
   logic [CTRL_W-1:0] ctrl_id;
   logic [31:0]       imem_addr, ifid_instr, ifid_pc4;
   logic              ifid_valid, stall_timeout;
   logic [CTRL_W-1:0] idex_ctrl;
   logic [CNT_W-1:0]  stall_count, flush_count;

   fetch_pipeline_ctrl #(
      .RESET_PC (32'h0000_0000),
      .CTRL_W   (CTRL_W),
      .CNT_W    (CNT_W),
      .MAX_STALL(MAX_STALL)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .pc_write     (pc_write),
      .ifid_write   (ifid_write),
      .ifid_flush   (ifid_flush),
      .control_mux  (control_mux),
      .branch_taken (branch_taken),
      .branch_target(branch_target),
      .imem_instr   (imem_instr),
      .ctrl_id      (ctrl_id),
      .imem_addr    (imem_addr),
      .ifid_instr   (ifid_instr),
      .ifid_pc4     (ifid_pc4),
      .ifid_valid   (ifid_valid),
      .idex_ctrl    (idex_ctrl),
      .stall_count  (stall_count),
      .flush_count  (flush_count),
      .stall_timeout(stall_timeout)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] imem(input logic [31:0] a);
      return 32'hA5A5_0000 ^ a;
   endfunction

   assign imem_instr = imem(imem_addr);

   typedef enum {SigPc, SigInstr, SigPc4, SigValid, SigIdex, SigStall, SigFlush, SigTmo} sig_e;

   sig_e        exp_sig[$];
   logic [31:0] exp_val[$];
   int          n_cmp = 0;
   int          n_err = 0;

   function automatic logic [31:0] observe(input sig_e s);
      case (s)
         SigPc:    return imem_addr;
         SigInstr: return ifid_instr;
         SigPc4:   return ifid_pc4;
         SigValid: return 32'(ifid_valid);
         SigIdex:  return 32'(idex_ctrl);
         SigStall: return 32'(stall_count);
         SigFlush: return 32'(flush_count);
         default:  return 32'(stall_timeout);
      endcase
   endfunction

   task automatic push(input sig_e s, input logic [31:0] v);
      exp_sig.push_back(s);
      exp_val.push_back(v);
   endtask

   task automatic drain();
      sig_e        s;
      logic [31:0] e, o;
      while (exp_sig.size() > 0) begin
         s = exp_sig.pop_front();
         e = exp_val.pop_front();
         o = observe(s);
         n_cmp++;
         assert (o === e) else begin
            n_err++;
            $display("FAIL %s: observed %h expected %h", s.name(), o, e);
            $error("%s observed %h expected %h", s.name(), o, e);
         end
      end
   endtask

   task automatic push_ifid(input logic [31:0] instr, input logic [31:0] pc4, input logic v);
      push(SigInstr, instr);
      push(SigPc4, pc4);
      push(SigValid, 32'(v));
   endtask

   task automatic push_reset_state();
      push(SigPc, 32'h0);
      push_ifid(32'h0, 32'h0, 1'b0);
      push(SigIdex, 32'h0);
      push(SigStall, 32'h0);
      push(SigFlush, 32'h0);
      push(SigTmo, 32'h0);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: observed no finish expected finish");
      $fatal(1, "bench timeout");
   end

   initial begin
      reset         = 1'b1;
      pc_write      = 1'b1;
      ifid_write    = 1'b1;
      ifid_flush    = 1'b0;
      control_mux   = 1'b1;
      branch_taken  = 1'b0;
      branch_target = 32'h0;
      ctrl_id       = 10'h155;
      #2;
      push_reset_state();
      drain();
      reset = 1'b0;

      // Sequential fetch
      push(SigPc, 32'h4); push_ifid(imem(32'h0), 32'h4, 1'b1); push(SigIdex, 32'h155);
      tick(); drain();
      push(SigPc, 32'h8); push_ifid(imem(32'h4), 32'h8, 1'b1);
      tick(); drain();

      // Load-use stall at PC=8
      pc_write = 1'b0; ifid_write = 1'b0; control_mux = 1'b0;
      push(SigPc, 32'h8); push_ifid(imem(32'h4), 32'h8, 1'b1);
      push(SigIdex, 32'h0); push(SigStall, 32'h1);
      tick(); drain();
      pc_write = 1'b1; ifid_write = 1'b1; control_mux = 1'b1;
      push(SigPc, 32'hC); push_ifid(imem(32'h8), 32'hC, 1'b1); push(SigIdex, 32'h155);
      tick(); drain();

      // Taken branch with flush
      ctrl_id = 10'h2AA; ifid_write = 1'b0; ifid_flush = 1'b1;
      branch_taken = 1'b1; branch_target = 32'h43;
      push(SigPc, 32'h40); push_ifid(32'h0, 32'h0, 1'b0);
      push(SigFlush, 32'h1); push(SigIdex, 32'h2AA);
      tick(); drain();

      // Stall wins over branch; flush still clears IF/ID despite ifid_write
      pc_write = 1'b0; ifid_write = 1'b1; branch_target = 32'h100;
      push(SigPc, 32'h40); push_ifid(32'h0, 32'h0, 1'b0);
      push(SigFlush, 32'h2); push(SigStall, 32'h2);
      tick(); drain();
      pc_write = 1'b1; ifid_flush = 1'b0; branch_taken = 1'b0;
      push(SigPc, 32'h44); push_ifid(imem(32'h40), 32'h44, 1'b1); push(SigTmo, 32'h0);
      tick(); drain();

      // Watchdog: trips on the MAX_STALL-th consecutive stall
      pc_write = 1'b0; ifid_write = 1'b0;
      for (int i = 1; i <= 8; i++) begin
         push(SigTmo, (i == 8) ? 32'h1 : 32'h0);
         push(SigStall, 32'(2 + i));
         tick(); drain();
      end
      push(SigPc, 32'h44);
      drain();
      pc_write = 1'b1; ifid_write = 1'b1;
      push(SigTmo, 32'h1); push(SigPc, 32'h48); push(SigStall, 32'd10);
      tick(); drain();

      // Stall counter saturation at 4'hF
      pc_write = 1'b0;
      for (int i = 1; i <= 20; i++) begin
         push(SigStall, (10 + i > 15) ? 32'd15 : 32'(10 + i));
         tick(); drain();
      end
      push(SigTmo, 32'h1); push(SigPc, 32'h48);
      drain();

      // Branch to unaligned top of memory, then PC wrap
      pc_write = 1'b1; branch_taken = 1'b1; branch_target = 32'hFFFF_FFFF;
      push(SigPc, 32'hFFFF_FFFC); push_ifid(imem(32'h48), 32'h4C, 1'b1);
      tick(); drain();
      branch_taken = 1'b0;
      push(SigPc, 32'h0); push_ifid(imem(32'hFFFF_FFFC), 32'h0, 1'b1);
      tick(); drain();

      // Asynchronous reset in the middle of a stall and flush
      pc_write = 1'b0; ifid_flush = 1'b1;
      tick();
      #3;
      reset = 1'b1;
      #1;
      push_reset_state();
      drain();
      tick();
      push_reset_state();
      drain();
      reset = 1'b0; pc_write = 1'b1; ifid_flush = 1'b0; ctrl_id = 10'h0F0;
      push(SigPc, 32'h0);
      drain();
      push(SigPc, 32'h4); push_ifid(imem(32'h0), 32'h4, 1'b1); push(SigIdex, 32'h0F0);
      push(SigStall, 32'h0); push(SigFlush, 32'h0); push(SigTmo, 32'h0);
      tick(); drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
